data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Memory-side responder for the pipeline's data-memory load/store port. It accepts one request at a time over a valid/ready handshake and inserts a configurable number of wait states. It then performs the byte/half/word access with RISC-V funct3 sizing and sign extension, and returns the read data and an error flag over a second valid/ready handshake. It sits between the core's MEM-stage load/store initiator and the on-chip data RAM, and obeys the same global clock enable as the core.

## Interface
- XLEN, 32, data and address width
- DEPTH_WORDS, 1024, RAM depth in XLEN-bit words; power of two
- WAIT_CYCLES, 1, wait states inserted before the access; legal range 0..15

- i_clk  in  1  system clock
- i_rst  in  1  reset, asynchronous, active-high
- i_clk_en  in  1  global clock enable; when 0, all state and outputs hold
- i_req_valid  in  1  request present
- o_req_ready  out  1  responder can accept a request
- i_req_we  in  1  1 = store, 0 = load
- i_req_addr  in  XLEN  byte address
- i_req_wdata  in  XLEN  store data, right-aligned
- i_req_f3  in  3  funct3 (size and signedness)
- o_rsp_valid  out  1  response present
- i_rsp_ready  in  1  initiator consumes the response
- o_rsp_rdata  out  XLEN  load result, already extended
- o_rsp_err  out  1  access was rejected

## Operation
- FSM states: IDLE, WAIT, RESP. Reset puts the FSM in IDLE.
- Reset values: o_req_ready=1, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0. RAM contents are not reset.
- IDLE
  - o_req_ready=1.
  - On i_req_valid & o_req_ready at an enabled edge: latch we/addr/wdata/f3, load counter=WAIT_CYCLES, go to WAIT.
- WAIT
  - o_req_ready=0.
  - Counter≠0: decrement.
  - Counter=0: perform the access, register rdata/err, go to RESP.
- RESP
  - o_rsp_valid=1; rdata and err are stable.
  - On i_rsp_ready at an enabled edge: go to IDLE, drop o_rsp_valid, clear rdata and err to 0.
- Legal loads (funct3)
  - 000 LB, 001 LH: sign-extended.
  - 010 LW.
  - 100 LBU, 101 LHU: zero-extended.
- Legal stores (funct3)
  - 000 SB: one byte lane, selected by addr[1:0].
  - 001 SH: lanes {addr[1],0} and {addr[1],1}.
  - 010 SW: all lanes.
  - Untouched bytes keep their old value.
- Error conditions; any one sets err:
  - Illegal funct3.
  - Half access with addr[0]=1.
  - Word access with addr[1:0]≠0.
  - Word index addr[XLEN-1:2] ≥ DEPTH_WORDS.
- On error: no RAM write, rdata=0, err=1.
- Stores always return rdata=0.
- Word index is addr[2+$clog2(DEPTH_WORDS)-1:2]. Upper address bits are used only for the range check; there is no wrap-around.

## Timing
- i_clk_en=0: no handshake completes and no counter or FSM movement. Outputs hold their values.
- Latency: request accepted at enabled edge E0 → o_rsp_valid high after enabled edge E0+WAIT_CYCLES+1.
- With WAIT_CYCLES=0, the response is valid after the next enabled edge.
- One outstanding request.
  - o_req_ready=0 from the accept edge until the edge on which the response is consumed.
  - Minimum spacing between accepts: WAIT_CYCLES+3 enabled edges.
- The RAM write happens only at the WAIT→RESP edge. A store is never written twice, even if RESP stalls on i_rsp_ready=0.
- Load data is sampled at the WAIT→RESP edge and held throughout RESP.
- i_req_valid while o_req_ready=0 is ignored; the initiator must hold the request until it is accepted.
- Reset asserted mid-transaction: the FSM goes to IDLE immediately and the response is dropped.
  - A store that has not yet reached the WAIT→RESP edge is discarded.
  - A store that already did is retained.

## Structure
- Package data_mem_pkg holds:
  - FSM state enum.
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - The WAIT_CYCLES counter width (4).
- Sub-module load_store_align is purely combinational. It maps (f3, addr[1:0], wdata, rword) to:
  - byte-enable mask,
  - shifted write data,
  - extended load data,
  - misalignment/illegal flag.
- The top level holds the FSM, counter, request latches, RAM array and range check.

## Test plan
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → rdata=0xDEADBEEF, err=0. o_rsp_valid rises exactly WAIT_CYCLES+1 edges after each accept.
- SB 0x13 data 0x80, then LB 0x13 → 0xFFFFFF80; LBU 0x13 → 0x00000080; LW 0x10 → 0x80ADBEEF.
- SH addr 0x11 → err=1, RAM unchanged (verify with LW 0x10). LW addr 4*DEPTH_WORDS → err=1, rdata=0. f3=011 → err=1.
- Hold i_rsp_ready=0 for 5 cycles in RESP after SW 0x20 data 1 → rdata/err stable, o_req_ready=0; after consume, LW 0x20 → 1 (single write).
- Drop i_clk_en for 4 cycles mid-WAIT → no state change; latency is extended by exactly 4 cycles.
- Assert i_rst during WAIT of SW 0x30 data 5 (pre-stored value 7) → o_rsp_valid=0, o_req_ready=1 immediately; after release, LW 0x30 → 7.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory responder.
package data_mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/load_store_align.sv
// Combinational lane steering: byte enables, store data replication,
// load extraction/extension and size/alignment legality.
module load_store_align
    import data_mem_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic              we,
    input  logic [2:0]        f3,
    input  logic [1:0]        addr_lo,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   rword,
    output logic [XLEN/8-1:0] be_c,
    output logic [XLEN-1:0]   wdata_c,
    output logic [XLEN-1:0]   rdata_c,
    output logic              bad_c
);

    localparam int unsigned NB = XLEN / 8;

    logic [7:0]  rb;
    logic [15:0] rh;

    assign rb = rword[{addr_lo, 3'b000} +: 8];
    assign rh = rword[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        be_c    = '0;
        wdata_c = '0;
        rdata_c = '0;
        bad_c   = 1'b0;
        case (f3)
            F3_B: begin
                be_c    = NB'(1) << addr_lo;
                wdata_c = {NB{wdata[7:0]}};
                rdata_c = {{(XLEN-8){rb[7]}}, rb};
            end
            F3_H: begin
                bad_c   = addr_lo[0];
                be_c    = NB'(2'b11) << {addr_lo[1], 1'b0};
                wdata_c = {(NB/2){wdata[15:0]}};
                rdata_c = {{(XLEN-16){rh[15]}}, rh};
            end
            F3_W: begin
                bad_c   = (addr_lo != 2'b00);
                be_c    = '1;
                wdata_c = wdata;
                rdata_c = rword;
            end
            // Unsigned variants exist only for loads
            F3_BU: begin
                bad_c   = we;
                rdata_c = XLEN'(rb);
            end
            F3_HU: begin
                bad_c   = we | addr_lo[0];
                rdata_c = XLEN'(rh);
            end
            default: bad_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one outstanding request, programmable wait states,
// sized RAM access and a held response.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_clk_en,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic            i_req_we,
    input  logic [XLEN-1:0] i_req_addr,
    input  logic [XLEN-1:0] i_req_wdata,
    input  logic [2:0]      i_req_f3,
    output logic            o_rsp_valid,
    input  logic            i_rsp_ready,
    output logic [XLEN-1:0] o_rsp_rdata,
    output logic            o_rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned NB = XLEN / 8;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q, rsp_err_d;
    logic [XLEN-1:0]  rsp_rdata_q, rsp_rdata_d;

    logic             we_q;
    logic [XLEN-1:0]  addr_q;
    logic [XLEN-1:0]  wdata_q;
    logic [2:0]       f3_q;

    logic             accept_c;
    logic             write_c;

    logic [XLEN-1:0]  mem [DEPTH_WORDS];
    logic [AW-1:0]    widx;
    logic [XLEN-1:0]  rword;
    logic [XLEN-1:0]  wdata_sh;
    logic [XLEN-1:0]  ld_data;
    logic [NB-1:0]    be;
    logic             align_bad;
    logic             range_bad;
    logic             acc_err;

    assign widx      = addr_q[2 +: AW];
    assign rword     = mem[widx];
    // Full upper address takes part in the range check; no aliasing
    assign range_bad = addr_q[XLEN-1:2] >= (XLEN-2)'(DEPTH_WORDS);
    assign acc_err   = align_bad | range_bad;

    load_store_align #(.XLEN(XLEN)) u_align (
        .we      (we_q),
        .f3      (f3_q),
        .addr_lo (addr_q[1:0]),
        .wdata   (wdata_q),
        .rword   (rword),
        .be_c    (be),
        .wdata_c (wdata_sh),
        .rdata_c (ld_data),
        .bad_c   (align_bad)
    );

    // FSM and response registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        accept_c    = 1'b0;
        write_c     = 1'b0;
        if (i_clk_en) begin
            case (state_q)
                S_IDLE: begin
                    if (i_req_valid && req_ready_q) begin
                        accept_c    = 1'b1;
                        cnt_d       = CNT_W'(WAIT_CYCLES);
                        req_ready_d = 1'b0;
                        state_d     = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        write_c     = we_q & ~acc_err;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = acc_err;
                        rsp_rdata_d = (acc_err || we_q) ? '0 : ld_data;
                        state_d     = S_RESP;
                    end
                end
                S_RESP: begin
                    if (i_rsp_ready) begin
                        rsp_valid_d = 1'b0;
                        rsp_err_d   = 1'b0;
                        rsp_rdata_d = '0;
                        req_ready_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
        end else if (accept_c) begin
            we_q    <= i_req_we;
            addr_q  <= i_req_addr;
            wdata_q <= i_req_wdata;
            f3_q    <= i_req_f3;
        end
    end

    // RAM contents survive reset; only the WAIT->RESP edge writes
    always_ff @(posedge i_clk) begin
        if (write_c) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (be[i]) mem[widx][8*i +: 8] <= wdata_sh[8*i +: 8];
            end
        end
    end

    assign o_req_ready = req_ready_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed vector table, corner
// sequences and random traffic against a byte-addressed reference memory.
module tb_data_mem_responder;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned WAITC = 1;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_clk_en;
    logic              i_req_valid;
    logic              o_req_ready;
    logic              i_req_we;
    logic [XLEN-1:0]   i_req_addr;
    logic [XLEN-1:0]   i_req_wdata;
    logic [2:0]        i_req_f3;
    logic              o_rsp_valid;
    logic              i_rsp_ready;
    logic [XLEN-1:0]   o_rsp_rdata;
    logic              o_rsp_err;

    data_mem_responder #(
        .XLEN        (XLEN),
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (WAITC)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clk_en    (i_clk_en),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_we    (i_req_we),
        .i_req_addr  (i_req_addr),
        .i_req_wdata (i_req_wdata),
        .i_req_f3    (i_req_f3),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_rdata (o_rsp_rdata),
        .o_rsp_err   (o_rsp_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    int total = 0;
    int bad   = 0;

    logic [7:0] mb [4*DEPTH];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference: byte-addressed little-endian memory with arithmetic extension
    function automatic void model_op(input logic we, input logic [31:0] addr,
                                     input logic [31:0] wdata, input logic [2:0] f3,
                                     output logic [31:0] rd, output logic er);
        int     size;
        bit     sgn;
        bit     legal;
        longint v;
        int     a;
        size  = 1;
        sgn   = 1'b0;
        legal = 1'b1;
        case (f3)
            3'd0: sgn = 1'b1;
            3'd1: begin size = 2; sgn = 1'b1; end
            3'd2: size = 4;
            3'd4: legal = !we;
            3'd5: begin size = 2; legal = !we; end
            default: legal = 1'b0;
        endcase
        er = !legal || ((addr % 32'(size)) != 0) || ((addr / 4) >= DEPTH);
        rd = '0;
        if (!er) begin
            a = int'(addr);
            if (we) begin
                for (int i = 0; i < size; i++) mb[a+i] = wdata[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < size; i++) v = v | (longint'(mb[a+i]) << (8*i));
                if (sgn && v[8*size-1]) v = v - (longint'(1) << (8*size));
                rd = v[31:0];
            end
        end
    endfunction

    // One full transaction; gap = disabled cycles right after accept, hold = RESP stall cycles
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] f3, input int gap, input int hold,
                       output logic [31:0] rd, output logic er, output int lat);
        logic ready_seen;
        ready_seen  = 1'b0;
        i_req_we    = we;
        i_req_addr  = addr;
        i_req_wdata = wdata;
        i_req_f3    = f3;
        i_req_valid = 1'b1;
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        lat = 0;
        while (!o_rsp_valid && lat < 64) begin
            i_clk_en = (lat < gap) ? 1'b0 : 1'b1;
            if (o_req_ready) ready_seen = 1'b1;
            @(posedge i_clk); #1;
            lat++;
        end
        i_clk_en = 1'b1;
        if (!o_rsp_valid) chk("rsp_timeout", 32'(o_rsp_valid), 32'd1);
        chk("busy_ready", 32'(ready_seen | o_req_ready), 32'd0);
        rd = o_rsp_rdata;
        er = o_rsp_err;
        for (int h = 0; h < hold; h++) begin
            @(posedge i_clk); #1;
            chk($sformatf("hold_flags[%0d]", h), {29'd0, o_rsp_valid, o_req_ready, o_rsp_err},
                {29'd0, 1'b1, 1'b0, er});
            chk($sformatf("hold_rdata[%0d]", h), o_rsp_rdata, rd);
        end
        i_rsp_ready = 1'b1;
        @(posedge i_clk); #1;
        i_rsp_ready = 1'b0;
        chk("idle_flags", {29'd0, o_req_ready, o_rsp_valid, o_rsp_err}, 32'b100);
        chk("idle_rdata", o_rsp_rdata, 32'd0);
    endtask

    vec_t        vecs [18];
    logic [31:0] rd, mrd, wd, ad;
    logic        er, mer, we;
    logic [2:0]  f3;
    int          lat, gap, hold, r;

    initial begin
        vecs[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 3'd2, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h10,   32'h0,        3'd2, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h13,   32'h80,       3'd0, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 32'h13,   32'h0,        3'd0, 32'hFFFFFF80, 1'b0};
        vecs[4]  = '{1'b0, 32'h13,   32'h0,        3'd4, 32'h00000080, 1'b0};
        vecs[5]  = '{1'b0, 32'h10,   32'h0,        3'd2, 32'h80ADBEEF, 1'b0};
        vecs[6]  = '{1'b1, 32'h11,   32'h1234,     3'd1, 32'h0,        1'b1};
        vecs[7]  = '{1'b0, 32'h10,   32'h0,        3'd2, 32'h80ADBEEF, 1'b0};
        vecs[8]  = '{1'b0, 32'h1000, 32'h0,        3'd2, 32'h0,        1'b1};
        vecs[9]  = '{1'b0, 32'h10,   32'h0,        3'd3, 32'h0,        1'b1};
        vecs[10] = '{1'b0, 32'h12,   32'h0,        3'd1, 32'hFFFF80AD, 1'b0};
        vecs[11] = '{1'b0, 32'h10,   32'h0,        3'd5, 32'h0000BEEF, 1'b0};
        vecs[12] = '{1'b1, 32'h12,   32'hCAFE,     3'd1, 32'h0,        1'b0};
        vecs[13] = '{1'b0, 32'h10,   32'h0,        3'd2, 32'hCAFEBEEF, 1'b0};
        vecs[14] = '{1'b1, 32'h10,   32'h0,        3'd4, 32'h0,        1'b1};
        vecs[15] = '{1'b0, 32'h12,   32'h0,        3'd2, 32'h0,        1'b1};
        vecs[16] = '{1'b0, 32'h10,   32'h0,        3'd2, 32'hCAFEBEEF, 1'b0};
        vecs[17] = '{1'b0, 32'h10,   32'h0,        3'd0, 32'hFFFFFFEF, 1'b0};

        for (int i = 0; i < 4*DEPTH; i++) mb[i] = 8'h00;

        i_rst       = 1'b1;
        i_clk_en    = 1'b1;
        i_req_valid = 1'b0;
        i_req_we    = 1'b0;
        i_req_addr  = '0;
        i_req_wdata = '0;
        i_req_f3    = '0;
        i_rsp_ready = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_req_ready", 32'(o_req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        chk("rst_rsp_rdata", o_rsp_rdata, 32'd0);
        chk("rst_rsp_err",   32'(o_rsp_err), 32'd0);
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        // Give the low 64 bytes known contents
        for (int w = 0; w < 16; w++) begin
            wd = $urandom;
            model_op(1'b1, 32'(4*w), wd, 3'd2, mrd, mer);
            txn(1'b1, 32'(4*w), wd, 3'd2, 0, 0, rd, er, lat);
            chk($sformatf("init_err[%0d]", w), 32'(er), 32'(mer));
        end

        for (int i = 0; i < 18; i++) begin
            model_op(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3, mrd, mer);
            txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3, 0, 0, rd, er, lat);
            chk($sformatf("vec_rdata[%0d]", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec_err[%0d]", i), 32'(er), 32'(vecs[i].exp_err));
            chk($sformatf("vec_lat[%0d]", i), 32'(lat), 32'(WAITC + 1));
        end

        // Stalled response must not re-write the store
        model_op(1'b1, 32'h20, 32'h1, 3'd2, mrd, mer);
        txn(1'b1, 32'h20, 32'h1, 3'd2, 0, 5, rd, er, lat);
        chk("stall_err", 32'(er), 32'd0);
        model_op(1'b0, 32'h20, 32'h0, 3'd2, mrd, mer);
        txn(1'b0, 32'h20, 32'h0, 3'd2, 0, 0, rd, er, lat);
        chk("stall_readback", rd, 32'h1);

        // Clock enable dropped for 4 cycles in WAIT stretches latency by 4
        model_op(1'b0, 32'h10, 32'h0, 3'd2, mrd, mer);
        txn(1'b0, 32'h10, 32'h0, 3'd2, 4, 0, rd, er, lat);
        chk("clken_lat", 32'(lat), 32'(WAITC + 1 + 4));
        chk("clken_rdata", rd, 32'hCAFEBEEF);

        // Reset during WAIT discards the pending store
        model_op(1'b1, 32'h30, 32'h7, 3'd2, mrd, mer);
        txn(1'b1, 32'h30, 32'h7, 3'd2, 0, 0, rd, er, lat);
        i_req_we    = 1'b1;
        i_req_addr  = 32'h30;
        i_req_wdata = 32'h5;
        i_req_f3    = 3'd2;
        i_req_valid = 1'b1;
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        chk("rstmid_busy", 32'(o_req_ready), 32'd0);
        i_rst = 1'b1;
        #1;
        chk("rstmid_ready", 32'(o_req_ready), 32'd1);
        chk("rstmid_valid", 32'(o_rsp_valid), 32'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        model_op(1'b0, 32'h30, 32'h0, 3'd2, mrd, mer);
        txn(1'b0, 32'h30, 32'h0, 3'd2, 0, 0, rd, er, lat);
        chk("rstmid_readback", rd, 32'h7);

        // Random traffic against the reference memory
        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      ad = 32'h1000 + ($urandom & 32'hFFC);
            else if (r == 1) ad = $urandom;
            else             ad = 32'($urandom_range(0, 63));
            we   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            wd   = $urandom;
            gap  = $urandom_range(0, 2);
            hold = $urandom_range(0, 2);
            model_op(we, ad, wd, f3, mrd, mer);
            txn(we, ad, wd, f3, gap, hold, rd, er, lat);
            chk($sformatf("rnd_rdata[%0d]", n), rd, mrd);
            chk($sformatf("rnd_err[%0d]", n), 32'(er), 32'(mer));
            chk($sformatf("rnd_lat[%0d]", n), 32'(lat), 32'(WAITC + 1 + gap));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
